uart_rx_deserializer: RTL
=========================

// Module: uart_rx_deserializer
// PURPOSE
//  Serial-to-parallel receive end of the team's USART: recovers 8-bit frames from rx_in.
//  Frame: 1 start (0), 8 data bits MSB-first, optional parity, 1 stop (1).
//  Synchronizes the asynchronous line, samples mid-bit, and holds each byte in a one-deep output register.
//  Byte leaves through a valid/ready handshake to the host-side logic.
// PARAMETERS
//  CLKS_PER_BIT   16   clk cycles per bit period; legal range 4..65535
//  PARITY_ODD     0    0 = even parity, 1 = odd; used only when UART_RX_PARITY_EN is defined
// PORTS
//  clk        in   1  clock
//  reset      in   1  synchronous, active-high reset
//  rx_in      in   1  asynchronous serial line, idle high
//  dout       out  8  received byte, held until the next accepted frame
//  dout_valid out  1  dout holds an unconsumed byte
//  dout_ready in   1  consumer accepts dout when dout_valid && dout_ready
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0
//  parity_err out  1  1-cycle pulse: parity mismatch; tied 0 without UART_RX_PARITY_EN
//  overrun    out  1  1-cycle pulse: frame completed while dout_valid=1 and not consumed that cycle
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  - Reset: every output 0, dout=8'h00, state=IDLE, counters 0; 2-FF synchronizer preset to 1.
//  - Reset mid-frame aborts the frame; no flags, no dout update.
//  - rx_in passes a 2-FF synchronizer; all logic below uses rx_s.
//  - Bit counter baud_cnt counts 0..CLKS_PER_BIT-1; sample point = CLKS_PER_BIT/2 (integer divide).
//  - FSM:
//    IDLE:   rx_s==0 -> START, baud_cnt=0.
//    START:  at sample point: rx_s==0 -> DATA, bit_idx=7; rx_s==1 -> IDLE (glitch, no flag).
//    DATA:   one sample per bit period, shifted into shreg MSB-first; after bit_idx==0 -> PARITY or STOP.
//    PARITY: (macro only) one sample; compare against XOR of data (^PARITY_ODD) -> STOP.
//    STOP:   sample at mid-bit; then -> IDLE immediately (no wait for end of stop bit).
//  - On STOP sample: dout<=shreg and dout_valid<=1 only if stop==1 and no parity error;
//    on stop==0 pulse frame_err, dout unchanged; on parity error pulse parity_err, dout unchanged.
//  - Bad frame: after IDLE, a line still low is treated as a new start edge (break = repeated frame_err).
//  - Latency: dout_valid rises 1 clk after the stop-bit sample cycle.
//  - Handshake: dout_valid clears the cycle after dout_valid&&dout_ready unless a new byte lands the same
//    cycle; then dout takes the new byte, dout_valid stays 1, no overrun.
//  - Overrun: new good frame while dout_valid=1 and dout_ready=0 -> dout overwritten with newest byte,
//    overrun pulses 1 cycle, dout_valid stays 1.
//  - frame_err, parity_err and overrun are mutually exclusive for a single frame.
//  - baud_cnt 16-bit; wraps to 0 at CLKS_PER_BIT-1; no free-running counter outside a frame.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present, frame = 11 bits, parity_err driven.
//  UART_RX_PARITY_EN undefined: no PARITY state, 10-bit frame, parity_err constant 0.
// TESTING
//  1. Reset 3 clks, rx_in=1 -> all outputs 0, busy=0, dout=8'h00.
//  2. Send 8'hCD (CLKS_PER_BIT=16), dout_ready=1 -> dout=8'hCD, dout_valid 1 clk, no error flags.
//  3. Send 8'hA5 with stop bit 0 -> frame_err 1 clk pulse, dout_valid stays 0, dout unchanged.
//  4. 6-clk low glitch on idle rx_in -> back to IDLE, busy drops, no flags, no dout_valid.
//  5. Send 8'h12 then 8'h34, dout_ready=0 -> overrun pulse on 2nd frame, dout=8'h34, dout_valid=1.
//  6. Macro on, PARITY_ODD=0, 8'h07 with parity 0 -> parity_err pulse; with parity 1 -> dout=8'h07.
//  7. Assert reset during DATA bit 4 -> idle immediately; next clean frame 8'h5A received correctly.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 2-FF synchronized line, mid-bit sampling, 8 data bits MSB-first,
// one-deep valid/ready output register. Define UART_RX_PARITY_EN to add the parity bit check.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] LAST_CNT   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] SAMPLE_CNT = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state, state_next;
  logic [15:0] baud_cnt, baud_next;
  logic [2:0]  bit_idx, bit_next;
  logic        rx_m, rx_s;
  logic [7:0]  shreg;
  logic        at_sample, shift_en, stop_smp, par_bad, good_frame;

`ifdef UART_RX_PARITY_EN
  logic par_smp;
  logic par_bit;

  // Expected parity bit for a data byte under the configured sense.
  function automatic logic parity_of(input logic [7:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_en   = 1'b0;
    stop_smp   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp    = 1'b0;
`endif
    at_sample  = (state != IDLE) && (baud_cnt == SAMPLE_CNT);
    if (state != IDLE)
      baud_next = (baud_cnt == LAST_CNT) ? 16'd0 : baud_cnt + 16'd1;
    case (state)
      IDLE: begin
        baud_next = 16'd0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (at_sample) begin
          if (rx_s) begin
            state_next = IDLE;
            baud_next  = 16'd0;
          end else begin
            state_next = DATA;
            bit_next   = 3'd7;
          end
        end
      end
      DATA: begin
        if (at_sample) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd0) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_idx - 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_sample) begin
          par_smp    = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        // Return to IDLE at mid-stop so the next start edge is never missed.
        if (at_sample) begin
          stop_smp   = 1'b1;
          state_next = IDLE;
          baud_next  = 16'd0;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = 16'd0;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign par_bad = (parity_of(shreg) != par_bit);
`else
  assign par_bad = 1'b0;
`endif

  assign good_frame = stop_smp && rx_s && !par_bad;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= 8'h00;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_smp && !rx_s;
      overrun   <= 1'b0;
      if (shift_en) shreg <= {shreg[6:0], rx_s};
      if (good_frame) begin
        dout       <= shreg;
        dout_valid <= 1'b1;
        overrun    <= dout_valid && !dout_ready;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_smp) par_bit <= rx_s;
      // A bad stop bit takes precedence so only one flag fires per frame.
      parity_err <= stop_smp && rx_s && par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
